// File: rtl/gerador_indices.sv
// Four-lane note spawner/retirer for the MindFocus game stage.
// Define TICK_EXTERNO_EN to drive game steps from tick_ext instead of the counter.
module gerador_indices #(
  parameter int          TICK_CICLOS = 25000000,
  parameter logic [7:0]  SEED        = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
`ifdef TICK_EXTERNO_EN
  input  logic       tick_ext,
`endif
  input  logic       iniciar,
  input  logic       parar,
  input  logic [3:0] jogada,
  output logic [7:0] indices,
  output logic [3:0] acertos,
  output logic [3:0] perdas,
  output logic       ativo,
  output logic       tick
);

  typedef enum logic {PARADO, RODANDO} estado_t;

  localparam logic [7:0] LFSR_INI = (SEED == 8'h00) ? 8'h01 : SEED;

  estado_t    r_estado;
  logic [7:0] r_lfsr;
  logic [7:0] r_ind;
  logic [3:0] r_acc;
  logic [3:0] r_per;

  logic       w_tick;
  logic [7:0] w_lfsr_nx;
  logic       w_spawn;
  logic [1:0] w_sel;
  logic [7:0] w_ind_nx;
  logic [3:0] w_acc_nx;
  logic [3:0] w_per_nx;

`ifdef TICK_EXTERNO_EN
  assign w_tick = (r_estado == RODANDO) && tick_ext;
`else
  localparam int CW = $clog2(TICK_CICLOS);

  logic [CW-1:0] r_cnt;

  assign w_tick = (r_estado == RODANDO) &&
                  (r_cnt == CW'(TICK_CICLOS - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_estado != RODANDO || parar || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`endif

  assign w_lfsr_nx = {r_lfsr[6:0],
                      r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_spawn   = w_lfsr_nx[7];
  assign w_sel     = w_lfsr_nx[1:0];

  // A hit wins over a same-cycle expiry; spawns only land on idle lanes.
  always_comb begin
    w_ind_nx = r_ind;
    w_acc_nx = '0;
    w_per_nx = '0;
    for (int k = 0; k < 4; k++) begin
      if (r_ind[2*k +: 2] == 2'b00 && jogada[k]) begin
        w_ind_nx[2*k +: 2] = 2'b11;
        w_acc_nx[k]        = 1'b1;
      end else if (w_tick) begin
        unique case (r_ind[2*k +: 2])
          2'b00: begin
            w_ind_nx[2*k +: 2] = 2'b11;
            w_per_nx[k]        = 1'b1;
          end
          2'b01: w_ind_nx[2*k +: 2] = 2'b00;
          2'b10: w_ind_nx[2*k +: 2] = 2'b01;
          2'b11: begin
            if (w_spawn && w_sel == 2'(k))
              w_ind_nx[2*k +: 2] = 2'b10;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= PARADO;
      r_lfsr   <= LFSR_INI;
      r_ind    <= 8'hFF;
      r_acc    <= '0;
      r_per    <= '0;
    end else begin
      r_acc <= '0;
      r_per <= '0;
      r_ind <= 8'hFF;
      unique case (r_estado)
        PARADO: begin
          if (iniciar)
            r_estado <= RODANDO;
        end
        RODANDO: begin
          if (parar) begin
            r_estado <= PARADO;
          end else begin
            r_ind <= w_ind_nx;
            r_acc <= w_acc_nx;
            r_per <= w_per_nx;
            if (w_tick)
              r_lfsr <= w_lfsr_nx;
          end
        end
      endcase
    end
  end

  assign indices = r_ind;
  assign acertos = r_acc;
  assign perdas  = r_per;
  assign ativo   = (r_estado == RODANDO);
  assign tick    = w_tick;

endmodule

// File: tb/tb_gerador_indices.sv
// Self-checking bench for gerador_indices: directed game runs plus a
// randomized run against a lane-level reference model.
module tb_gerador_indices;

  localparam int T = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       parar = 1'b0;
  logic [3:0] jogada = 4'h0;
  logic [7:0] indices;
  logic [3:0] acertos;
  logic [3:0] perdas;
  logic       ativo;
  logic       tick;
`ifdef TICK_EXTERNO_EN
  logic       tick_ext = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  int         m_lane [4];
  int         m_lfsr;
  int         m_cnt;
  bit         m_run;
  logic [3:0] m_acc;
  logic [3:0] m_per;

  gerador_indices #(
    .TICK_CICLOS(T),
    .SEED(8'hA5)
  ) dut (
    .clock(clock),
    .reset(reset),
`ifdef TICK_EXTERNO_EN
    .tick_ext(tick_ext),
`endif
    .iniciar(iniciar),
    .parar(parar),
    .jogada(jogada),
    .indices(indices),
    .acertos(acertos),
    .perdas(perdas),
    .ativo(ativo),
    .tick(tick)
  );

  always #5 clock = ~clock;

  function automatic int lfsr_next(int v);
    int fb;
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return ((v * 2) % 256) + fb;
  endfunction

  function automatic logic [7:0] m_ind();
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += m_lane[k] << (2 * k);
    return 8'(s);
  endfunction

  function automatic bit m_tick();
    return m_run && (m_cnt == T - 1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_lane[k] = 3;
    m_lfsr = 8'hA5;
    m_cnt  = 0;
    m_run  = 0;
    m_acc  = 4'h0;
    m_per  = 4'h0;
  endtask

  task automatic model_step();
    int  old [4];
    bit  t;
    bit  sp;
    int  sl;
    m_acc = 4'h0;
    m_per = 4'h0;
    if (!m_run) begin
      if (iniciar) m_run = 1;
      m_cnt = 0;
      for (int k = 0; k < 4; k++) m_lane[k] = 3;
    end else if (parar) begin
      m_run = 0;
      m_cnt = 0;
      for (int k = 0; k < 4; k++) m_lane[k] = 3;
    end else begin
      t = (m_cnt == T - 1);
      m_cnt = t ? 0 : m_cnt + 1;
      for (int k = 0; k < 4; k++) old[k] = m_lane[k];
      for (int k = 0; k < 4; k++)
        if (old[k] == 0 && jogada[k]) begin
          m_lane[k] = 3;
          m_acc[k]  = 1'b1;
        end
      if (t) begin
        m_lfsr = lfsr_next(m_lfsr);
        sp = (m_lfsr >= 128);
        sl = m_lfsr % 4;
        for (int k = 0; k < 4; k++) begin
          if (m_acc[k]) continue;
          if (old[k] == 0) begin
            m_lane[k] = 3;
            m_per[k]  = 1'b1;
          end else if (old[k] < 3) begin
            m_lane[k] = old[k] - 1;
          end else if (sp && sl == k) begin
            m_lane[k] = 2;
          end
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    if (!reset) model_reset();
    else model_step();
    @(negedge clock);
  endtask

  task automatic hard_reset();
    @(negedge clock);
    reset = 1'b0;
    #2;
    model_reset();
    reset = 1'b1;
  endtask

  task automatic start();
    iniciar = 1'b1;
    cyc();
    iniciar = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    total++;
    if (indices !== 8'hFF || ativo !== 1'b0 || tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: ind=%h ativo=%b tick=%b want FF 0 0",
               indices, ativo, tick);
    end
    total++;
    if (acertos !== 4'h0 || perdas !== 4'h0) begin
      bad++;
      $display("FAIL reset_pulses: acc=%b per=%b want 0", acertos, perdas);
    end
    reset = 1'b1;
    repeat (6) cyc();
    total++;
    if (indices !== 8'hFF || ativo !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: ind=%h ativo=%b want FF 0",
               indices, ativo);
    end
  endtask

  task automatic test_sequence();
    logic [7:0] exp [4];
    exp[0] = 8'hFF; exp[1] = 8'hFB; exp[2] = 8'hF7; exp[3] = 8'hF3;
    hard_reset();
    start();
    total++;
    if (ativo !== 1'b1) begin
      bad++;
      $display("FAIL ativo_on_start: got %b want 1", ativo);
    end
    for (int k = 0; k < 4; k++) begin
      repeat (T - 1) cyc();
      total++;
      if (tick !== 1'b1) begin
        bad++;
        $display("FAIL tick_%0d: got %b want 1", k + 1, tick);
      end
      cyc();
      total++;
      if (indices !== exp[k] || tick !== 1'b0) begin
        bad++;
        $display("FAIL travel_%0d: ind=%h tick=%b want %h 0",
                 k + 1, indices, tick, exp[k]);
      end
    end
  endtask

  task automatic test_miss();
    hard_reset();
    start();
    repeat (4 * T) cyc();
    repeat (T) cyc();
    total++;
    if (indices !== 8'hFF || perdas !== 4'b0010 || acertos !== 4'h0) begin
      bad++;
      $display("FAIL miss: ind=%h per=%b acc=%b want FF 0010 0000",
               indices, perdas, acertos);
    end
    cyc();
    total++;
    if (perdas !== 4'h0) begin
      bad++;
      $display("FAIL miss_pulse_width: per=%b want 0000", perdas);
    end
  endtask

  task automatic test_hit();
    hard_reset();
    start();
    repeat (4 * T) cyc();
    jogada = 4'b0010;
    cyc();
    jogada = 4'b0000;
    total++;
    if (acertos !== 4'b0010 || indices !== 8'hFF || perdas !== 4'h0) begin
      bad++;
      $display("FAIL hit: acc=%b ind=%h per=%b want 0010 FF 0000",
               acertos, indices, perdas);
    end
    repeat (T - 1) cyc();
    total++;
    if (perdas !== 4'h0 || acertos !== 4'h0 || indices !== m_ind()) begin
      bad++;
      $display("FAIL hit_then_tick: per=%b acc=%b ind=%h want 0000 0000 %h",
               perdas, acertos, indices, m_ind());
    end
  endtask

  task automatic test_wrong_lane();
    hard_reset();
    start();
    repeat (4 * T) cyc();
    jogada = 4'b0001;
    cyc();
    jogada = 4'b0000;
    total++;
    if (acertos !== 4'h0 || perdas !== 4'h0 || indices !== 8'hF3) begin
      bad++;
      $display("FAIL wrong_lane: acc=%b per=%b ind=%h want 0000 0000 F3",
               acertos, perdas, indices);
    end
    repeat (T - 1) cyc();
    total++;
    if (perdas !== 4'b0010 || indices !== 8'hFF) begin
      bad++;
      $display("FAIL wrong_lane_expiry: per=%b ind=%h want 0010 FF",
               perdas, indices);
    end
  endtask

  task automatic test_control();
    hard_reset();
    start();
    cyc();
    cyc();
    iniciar = 1'b1;
    cyc();
    iniciar = 1'b0;
    total++;
    if (tick !== 1'b1 || ativo !== 1'b1) begin
      bad++;
      $display("FAIL iniciar_ignored: tick=%b ativo=%b want 1 1",
               tick, ativo);
    end
    repeat (4 * T) cyc();
    parar   = 1'b1;
    iniciar = 1'b1;
    cyc();
    parar   = 1'b0;
    iniciar = 1'b0;
    total++;
    if (ativo !== 1'b0 || indices !== 8'hFF ||
        acertos !== 4'h0 || perdas !== 4'h0) begin
      bad++;
      $display("FAIL parar_priority: ativo=%b ind=%h acc=%b per=%b",
               ativo, indices, acertos, perdas);
    end
    repeat (2 * T) cyc();
    total++;
    if (ativo !== 1'b0 || tick !== 1'b0 || indices !== 8'hFF) begin
      bad++;
      $display("FAIL stays_parado: ativo=%b tick=%b ind=%h want 0 0 FF",
               ativo, tick, indices);
    end
  endtask

  task automatic test_midrun_reset();
    hard_reset();
    start();
    repeat (3 * T + 2) cyc();
    reset = 1'b0;
    #1;
    total++;
    if (indices !== 8'hFF || ativo !== 1'b0 || tick !== 1'b0 ||
        acertos !== 4'h0 || perdas !== 4'h0) begin
      bad++;
      $display("FAIL async_reset: ind=%h ativo=%b tick=%b acc=%b per=%b",
               indices, ativo, tick, acertos, perdas);
    end
    model_reset();
    #1;
    reset = 1'b1;
    repeat (3) cyc();
    total++;
    if (indices !== 8'hFF || ativo !== 1'b0) begin
      bad++;
      $display("FAIL after_midrun_reset: ind=%h ativo=%b want FF 0",
               indices, ativo);
    end
  endtask

  task automatic test_random();
    int errs;
    hard_reset();
    start();
    errs = 0;
    for (int n = 0; n < 3000; n++) begin
      jogada  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      parar   = ($urandom_range(0, 299) == 0);
      iniciar = ($urandom_range(0, 29) == 0);
      cyc();
      total++;
      if (indices !== m_ind() || acertos !== m_acc || perdas !== m_per ||
          ativo !== m_run || tick !== m_tick()) begin
        bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_%0d: ind=%h acc=%b per=%b a=%b t=%b want %h %b %b %b %b",
                   n, indices, acertos, perdas, ativo, tick,
                   m_ind(), m_acc, m_per, m_run, m_tick());
      end
    end
    jogada  = 4'h0;
    parar   = 1'b0;
    iniciar = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequence();
    test_miss();
    test_hit();
    test_wrong_lane();
    test_control();
    test_midrun_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
